// File: rtl/add_head_frame_pkg.sv
// Shared definitions for the PAM frame assembler.
//   state_e     : frame assembler FSM encoding
//   PRBS_SEED   : head sequence seed, reloaded at the start of every frame
//   prbs7_next  : one step of the x^7+x^6+1 head sequence generator
//   frame_len   : samples per frame for a given parameter set
package add_head_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEAD    = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PILOT   = 3'd3,
        ST_GUARD   = 3'd4
    } state_e;

    localparam logic [6:0] PRBS_SEED = 7'h7F;

    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    function automatic int frame_len(input int head_len, input int spw,
                                     input int payload_words, input int pilot_period,
                                     input int pilot_len, input int guard_len);
        int n_pilots;
        n_pilots = (pilot_period == 0) ? 0 : (payload_words - 1) / pilot_period;
        return head_len + spw * payload_words + pilot_len * n_pilots + guard_len;
    endfunction

endpackage

// File: rtl/fifo_sync_fwft.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst_n    : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en_i       : write request; taken when not full, or when full with a read in the same cycle
//   wr_data_i     : write data
//   rd_en_i       : pop the head word; ignored when empty
//   rd_data_o     : head word, valid whenever empty_o is low
//   full_o, empty_o, count_o : occupancy status
module fifo_sync_fwft #(
    parameter int WIDTH = 24,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr, do_rd;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_wr && !do_rd)      count_q <= count_q + 1'b1;
            else if (!do_wr && do_rd) count_q <= count_q - 1'b1;
        end
    end
endmodule

// File: rtl/add_head_frame_pilot.sv
// Frame assembler between the PAM mapper and the DAC.
// Buffers packed PAM words and emits one sample per clock as frames of
// PRBS7 head, payload (lane 0 first), periodic pilot blocks and a zero guard.
//   clk, rst_n              : clock, asynchronous active-low reset
//   en                      : allow new frames to start
//   PamMap2AddHead_*        : input word valid/ready handshake
//   sent_data, sent_valid   : registered DAC sample and in-frame flag
//   frame_sof               : pulse on head sample 0
//   underrun                : pulse on each payload sample with no data
//
// state   | meaning
// IDLE    | waiting for en and START_THRESH buffered words
// HEAD    | emitting PRBS7 head, cnt = head sample index
// PAYLOAD | emitting word lanes, cnt = words since last pilot
// PILOT   | emitting alternating +/- pilot, cnt = pilot sample index
// GUARD   | emitting zero guard samples, cnt = guard sample index
module add_head_frame_pilot
    import add_head_frame_pkg::*;
#(
    parameter int AD_CVER_WIDTH = 12,
    parameter int SPW           = 2,
    parameter int FIFO_AW       = 5,
    parameter int HEAD_LEN      = 32,
    parameter int PAYLOAD_WORDS = 16,
    parameter int PILOT_PERIOD  = 4,
    parameter int PILOT_LEN     = 2,
    parameter int GUARD_LEN     = 4,
    parameter int HEAD_AMP      = 1024,
    parameter int START_THRESH  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [SPW*AD_CVER_WIDTH-1:0] PamMap2AddHead_data,
    input  logic                         PamMap2AddHead_valid,
    output logic                         PamMap2AddHead_ready,
    output logic [AD_CVER_WIDTH-1:0]     sent_data,
    output logic                         sent_valid,
    output logic                         frame_sof,
    output logic                         underrun
);
    localparam int DW = AD_CVER_WIDTH;
    localparam int CW = 12;
    localparam int LW = (SPW > 1) ? $clog2(SPW) : 1;
    localparam logic [DW-1:0] AMP_P = DW'(HEAD_AMP);
    localparam logic [DW-1:0] AMP_N = ~AMP_P + 1'b1;

    logic [SPW*DW-1:0] fifo_rd_data;
    logic              fifo_full, fifo_empty, pop;
    logic [FIFO_AW:0]  fifo_count, occ_after;
    logic [DW-1:0]     lane_sample;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, word_q, word_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [6:0]        lfsr_q, lfsr_d;
    logic              starve_q, starve_d, starved, frame_end, start_ok;
    logic [DW-1:0]     data_d;
    logic              valid_d, sof_d, und_d;

    fifo_sync_fwft #(.WIDTH(SPW*DW), .AW(FIFO_AW)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (PamMap2AddHead_valid && PamMap2AddHead_ready),
        .wr_data_i(PamMap2AddHead_data),
        .rd_en_i  (pop),
        .rd_data_o(fifo_rd_data),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    assign PamMap2AddHead_ready = !fifo_full;
    assign lane_sample          = fifo_rd_data[lane_q*DW +: DW];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        lane_d    = lane_q;
        lfsr_d    = lfsr_q;
        starve_d  = starve_q;
        starved   = 1'b0;
        data_d    = '0;
        valid_d   = 1'b0;
        sof_d     = 1'b0;
        und_d     = 1'b0;
        pop       = 1'b0;
        frame_end = 1'b0;
        unique case (state_q)
            ST_HEAD: begin
                valid_d = 1'b1;
                data_d  = lfsr_q[6] ? AMP_P : AMP_N;
                sof_d   = (cnt_q == '0);
                lfsr_d  = prbs7_next(lfsr_q);
                if (cnt_q == CW'(HEAD_LEN - 1)) begin
                    state_d = ST_PAYLOAD;
                    cnt_d   = '0;
                    word_d  = '0;
                    lane_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PAYLOAD: begin
                valid_d = 1'b1;
                // Starvation is decided once per word so a word arriving
                // mid-word is held until the next word boundary.
                starved  = (lane_q == '0) ? fifo_empty : starve_q;
                starve_d = starved;
                if (starved) und_d  = 1'b1;
                else         data_d = lane_sample;
                if (lane_q == LW'(SPW - 1)) begin
                    pop    = !starved;
                    lane_d = '0;
                    word_d = word_q + 1'b1;
                    if (word_q == CW'(PAYLOAD_WORDS - 1)) begin
                        if (GUARD_LEN > 0) begin
                            state_d = ST_GUARD;
                            cnt_d   = '0;
                        end else begin
                            frame_end = 1'b1;
                        end
                    end else if ((PILOT_PERIOD != 0) && (cnt_q == CW'(PILOT_PERIOD - 1))) begin
                        state_d = ST_PILOT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            ST_PILOT: begin
                valid_d = 1'b1;
                data_d  = cnt_q[0] ? AMP_N : AMP_P;
                if (cnt_q == CW'(PILOT_LEN - 1)) begin
                    state_d = ST_PAYLOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GUARD: begin
                valid_d = 1'b1;
                if (cnt_q == CW'(GUARD_LEN - 1)) frame_end = 1'b1;
                else                             cnt_d = cnt_q + 1'b1;
            end
            default: ;
        endcase

        // Occupancy seen by the start decision excludes a word popped this cycle.
        occ_after = fifo_count - {{FIFO_AW{1'b0}}, pop};
        start_ok  = en && (occ_after >= (FIFO_AW+1)'(START_THRESH));

        if ((state_q == ST_IDLE) || frame_end) begin
            if (start_ok) begin
                state_d = ST_HEAD;
                cnt_d   = '0;
                lfsr_d  = PRBS_SEED;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            lane_q     <= '0;
            lfsr_q     <= PRBS_SEED;
            starve_q   <= 1'b0;
            sent_data  <= '0;
            sent_valid <= 1'b0;
            frame_sof  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            lane_q     <= lane_d;
            lfsr_q     <= lfsr_d;
            starve_q   <= starve_d;
            sent_data  <= data_d;
            sent_valid <= valid_d;
            frame_sof  <= sof_d;
            underrun   <= und_d;
        end
    end
endmodule

// File: doc/add_head_frame_pilot.md
Name: add_head_frame_pilot

Overview:
Next-generation frame assembler for the PAM transmit chain. It sits between the PAM mapper and the DAC and accepts packed multi-sample PAM words through a valid/ready handshake, buffered in a small FIFO. It emits one DAC sample per clock, forming frames of PRBS7 head, payload, periodic pilot blocks and a zero guard interval. All frame dimensions are parameters, and FIFO starvation mid-frame is handled explicitly.

Parameters:
AD_CVER_WIDTH, 12, DAC sample width; two's-complement signed.
SPW, 2, samples per input word; lane 0 (LSBs) is emitted first.
FIFO_AW, 5, input FIFO address width; depth is 2^FIFO_AW words.
HEAD_LEN, 32, head samples per frame (1..1023).
PAYLOAD_WORDS, 16, input words per frame (1..4095).
PILOT_PERIOD, 4, payload words between pilot blocks; 0 disables pilots.
PILOT_LEN, 2, samples per pilot block (1..255).
GUARD_LEN, 4, zero samples closing each frame (0..255).
HEAD_AMP, 1024, magnitude used for head and pilot samples.
START_THRESH, 1, FIFO occupancy in words required to start a frame.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active low
en  in  1  frame generation enable
PamMap2AddHead_data  in  SPW*AD_CVER_WIDTH  packed PAM samples
PamMap2AddHead_valid  in  1  input word valid
PamMap2AddHead_ready  out  1  FIFO can accept a word
sent_data  out  AD_CVER_WIDTH  DAC sample, registered
sent_valid  out  1  high on every in-frame sample
frame_sof  out  1  one-cycle pulse on head sample 0
underrun  out  1  one-cycle pulse on each starved payload sample

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; counters 0; PRBS register 7'h7F.
- Handshake: ready = FIFO not full, independent of valid. A word is written when valid && ready. Push and pop in the same cycle keep occupancy unchanged, and are legal even when the FIFO is full.
- FSM states: IDLE, HEAD, PAYLOAD, PILOT, GUARD.
- IDLE -> HEAD in the cycle en && occupancy >= START_THRESH. One cycle later: sent_data = head[0], frame_sof = 1, sent_valid = 1.
- HEAD: HEAD_LEN samples. Sample = +HEAD_AMP if PRBS bit is 1, else -HEAD_AMP.
  - PRBS7 x^7+x^6+1; bit = lfsr[6]; next = {lfsr[5:0], lfsr[6]^lfsr[5]}.
  - lfsr is reseeded to 7'h7F at the start of every frame.
- PAYLOAD: the word at the FIFO head is emitted lane 0..SPW-1, one sample per clock. It is popped on its last lane.
- Starvation: if the FIFO is empty when a new word is needed, each starved sample outputs 0 and pulses underrun. The word counter still advances, so frame length is fixed. If data arrives mid-word, emission resumes at the next word boundary.
- PILOT: inserted after every PILOT_PERIOD-th word, except after the final word. Samples alternate +HEAD_AMP, -HEAD_AMP, starting +HEAD_AMP in every block.
- GUARD: GUARD_LEN zero samples with sent_valid = 1. If GUARD_LEN = 0, the FSM goes straight from the last payload sample to the end-of-frame decision.
- End of frame: go back to HEAD with no gap if the start condition holds, else IDLE.
- Idle output: sent_data = 0, sent_valid = 0.
- Frame length = HEAD_LEN + SPW*PAYLOAD_WORDS + PILOT_LEN*floor((PAYLOAD_WORDS-1)/PILOT_PERIOD) + GUARD_LEN. With defaults this is 74.
- Enable: deasserting en never truncates a frame; the current frame completes.
- Reset mid-frame: immediate return to the reset state; buffered words are discarded.
- Arithmetic: -HEAD_AMP is the two's-complement negation at AD_CVER_WIDTH. HEAD_AMP must be < 2^(AD_CVER_WIDTH-1).

Decomposition:
- Package add_head_frame_pkg: FSM state encoding, PRBS7 seed and taps, a frame-length function.
- One sub-module: fifo_sync_fwft. Parametrised width and address width, with first-word-fall-through, full, empty and count outputs.

Test Plan:
- Defaults; continuous valid with data = i (lanes i*2+0, i*2+1, low 12 bits) -> sent_valid high for 74 cycles. Check head[0..6] = 0x400, head[7] = 0xC00; payload samples 32..39 = word data; pilot 0x400, 0xC00 at samples 40..41; last 4 samples 0; frame_sof once.
- Hold valid low for inputs 14 and 16, as in the existing bench -> samples follow input order with no duplication or loss; no underrun once the FIFO is pre-filled.
- Supply only 10 words, then stop -> underrun pulses for 12 samples (words 11..16 on 2 lanes); frame still exactly 74 samples; FSM returns to IDLE.
- Valid held high, sink permanently full after 32 words with en = 0 -> ready drops to 0 after 32 accepts; no write is lost. Raising en starts a frame one cycle later.
- en held high with plenty of data -> back-to-back frames; frame_sof spaced exactly 74 cycles apart; PRBS reseeded each frame.
- Assert rst_n low mid-PAYLOAD -> all outputs 0 asynchronously. After release, the FSM waits in IDLE for START_THRESH new words.
